// File: rtl/eth_reg_access_arb.sv
// eth_reg_access_arb
// Arbitrates host-bus and MAC-side access to the MAC configuration/status
// register bank. One access is in service at a time: it is granted in IDLE,
// the bank is strobed (write) or sampled (read) in GRANT, and the winner
// sees Ack/Err/RData in ACK until it drops its request.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   HostReq/We/Addr/WData      host request set (held until HostAck)
//   HostAck/Err/RData          host completion, error flag, read data
//   MacReq/We/Addr/WData       MAC request set
//   MacAck/Err/RData           MAC completion, error flag, read data
//   RegWrite                   one-hot write strobes to the register instances
//   RegDataIn                  shared write data to the register instances
//   RegDataOut                 flattened bank read bus, reg i at [i*DATA_W +: DATA_W]
module eth_reg_access_arb #(
    parameter int                  NUM_REGS     = 16,
    parameter int                  ADDR_W       = 4,
    parameter int                  DATA_W       = 32,
    parameter logic [NUM_REGS-1:0] HOST_RO_MASK = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       HostReq,
    input  logic                       HostWe,
    input  logic [ADDR_W-1:0]          HostAddr,
    input  logic [DATA_W-1:0]          HostWData,
    output logic                       HostAck,
    output logic                       HostErr,
    output logic [DATA_W-1:0]          HostRData,
    input  logic                       MacReq,
    input  logic                       MacWe,
    input  logic [ADDR_W-1:0]          MacAddr,
    input  logic [DATA_W-1:0]          MacWData,
    output logic                       MacAck,
    output logic                       MacErr,
    output logic [DATA_W-1:0]          MacRData,
    output logic [NUM_REGS-1:0]        RegWrite,
    output logic [DATA_W-1:0]          RegDataIn,
    input  logic [NUM_REGS*DATA_W-1:0] RegDataOut
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;

    state_t              state_reg, state_next;
    logic                prio_mac_reg, prio_mac_next;   // 1: MAC wins a tie
    logic                win_mac_reg, win_mac_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                err_reg, err_next;
    logic [NUM_REGS-1:0] strobe_reg, strobe_next;
    logic [DATA_W-1:0]   din_reg, din_next;
    logic                host_ack_reg, host_ack_next;
    logic                host_err_reg, host_err_next;
    logic [DATA_W-1:0]   host_rdata_reg, host_rdata_next;
    logic                mac_ack_reg, mac_ack_next;
    logic                mac_err_reg, mac_err_next;
    logic [DATA_W-1:0]   mac_rdata_reg, mac_rdata_next;

    // Selection of the requester that would win if granted this cycle.
    logic                grant_mac;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NUM_REGS-1:0] sel_dec;
    logic                sel_err;
    logic [NUM_REGS-1:0] rd_dec;
    logic [DATA_W-1:0]   rd_terms [NUM_REGS];
    logic [DATA_W-1:0]   rd_word;

    assign grant_mac = MacReq & (~HostReq | prio_mac_reg);
    assign sel_we    = grant_mac ? MacWe    : HostWe;
    assign sel_addr  = grant_mac ? MacAddr  : HostAddr;
    assign sel_wdata = grant_mac ? MacWData : HostWData;

    // Address decoders: sel_dec drives the strobe and the legality checks,
    // rd_dec selects the read slice for the access in service. An address at
    // or beyond NUM_REGS decodes to all-zero.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign sel_dec[gi]  = (sel_addr == ADDR_W'(gi));
            assign rd_dec[gi]   = (addr_reg == ADDR_W'(gi));
            assign rd_terms[gi] = RegDataOut[gi*DATA_W +: DATA_W] & {DATA_W{rd_dec[gi]}};
        end
    endgenerate

    assign sel_err = ~(|sel_dec) | (~grant_mac & sel_we & (|(sel_dec & HOST_RO_MASK)));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word = rd_word | rd_terms[i];
        end
    end

    always_comb begin
        state_next      = state_reg;
        prio_mac_next   = prio_mac_reg;
        win_mac_next    = win_mac_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        err_next        = err_reg;
        strobe_next     = '0;
        din_next        = din_reg;
        host_ack_next   = host_ack_reg;
        host_err_next   = host_err_reg;
        host_rdata_next = host_rdata_reg;
        mac_ack_next    = mac_ack_reg;
        mac_err_next    = mac_err_reg;
        mac_rdata_next  = mac_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (HostReq | MacReq) begin
                    state_next    = GRANT;
                    win_mac_next  = grant_mac;
                    prio_mac_next = ~grant_mac;
                    we_next       = sel_we;
                    addr_next     = sel_addr;
                    err_next      = sel_err;
                    // Strobe is registered here so it is visible during GRANT.
                    if (sel_we & ~sel_err) begin
                        strobe_next = sel_dec;
                        din_next    = sel_wdata;
                    end
                end
            end
            GRANT: begin
                state_next = ACK;
                if (win_mac_reg) begin
                    mac_ack_next = 1'b1;
                    mac_err_next = err_reg;
                    if (err_reg) begin
                        mac_rdata_next = '0;
                    end else if (!we_reg) begin
                        mac_rdata_next = rd_word;
                    end
                end else begin
                    host_ack_next = 1'b1;
                    host_err_next = err_reg;
                    if (err_reg) begin
                        host_rdata_next = '0;
                    end else if (!we_reg) begin
                        host_rdata_next = rd_word;
                    end
                end
            end
            ACK: begin
                if (!(win_mac_reg ? MacReq : HostReq)) begin
                    state_next    = IDLE;
                    host_ack_next = 1'b0;
                    host_err_next = 1'b0;
                    mac_ack_next  = 1'b0;
                    mac_err_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            prio_mac_reg   <= 1'b0;
            win_mac_reg    <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            err_reg        <= 1'b0;
            strobe_reg     <= '0;
            din_reg        <= '0;
            host_ack_reg   <= 1'b0;
            host_err_reg   <= 1'b0;
            host_rdata_reg <= '0;
            mac_ack_reg    <= 1'b0;
            mac_err_reg    <= 1'b0;
            mac_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prio_mac_reg   <= prio_mac_next;
            win_mac_reg    <= win_mac_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            err_reg        <= err_next;
            strobe_reg     <= strobe_next;
            din_reg        <= din_next;
            host_ack_reg   <= host_ack_next;
            host_err_reg   <= host_err_next;
            host_rdata_reg <= host_rdata_next;
            mac_ack_reg    <= mac_ack_next;
            mac_err_reg    <= mac_err_next;
            mac_rdata_reg  <= mac_rdata_next;
        end
    end

    // The strobe is masked by Reset so a reset landing in GRANT never lets
    // the in-flight write reach the bank.
    assign RegWrite  = strobe_reg & {NUM_REGS{~Reset}};
    assign RegDataIn = din_reg;
    assign HostAck   = host_ack_reg;
    assign HostErr   = host_err_reg;
    assign HostRData = host_rdata_reg;
    assign MacAck    = mac_ack_reg;
    assign MacErr    = mac_err_reg;
    assign MacRData  = mac_rdata_reg;

endmodule

// File: tb/tb_eth_reg_access_arb.sv
`timescale 1ns/1ps
module tb_eth_reg_access_arb;
    localparam int          NREG    = 16;
    localparam logic [15:0] RO_MASK = 16'h0010;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset = 1'b1;
    logic        HostReq = 0, HostWe = 0, MacReq = 0, MacWe = 0;
    logic [3:0]  HostAddr = 0, MacAddr = 0;
    logic [31:0] HostWData = 0, MacWData = 0;
    logic        HostAck, HostErr, MacAck, MacErr;
    logic [31:0] HostRData, MacRData, RegDataIn;
    logic [15:0] RegWrite;
    logic [511:0] RegDataOut;

    eth_reg_access_arb #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32), .HOST_RO_MASK(RO_MASK)) dut (
        .Clk(Clk), .Reset(Reset),
        .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
        .HostAck(HostAck), .HostErr(HostErr), .HostRData(HostRData),
        .MacReq(MacReq), .MacWe(MacWe), .MacAddr(MacAddr), .MacWData(MacWData),
        .MacAck(MacAck), .MacErr(MacErr), .MacRData(MacRData),
        .RegWrite(RegWrite), .RegDataIn(RegDataIn), .RegDataOut(RegDataOut));

    // Second instance with a 12-register bank for the out-of-range case.
    logic        m12_req = 0;
    logic [3:0]  m12_addr = 0;
    logic        h12_ack, h12_err, m12_ack, m12_err;
    logic [31:0] h12_rd, m12_rd, d12_in;
    logic [11:0] w12;
    logic [383:0] rdo12;

    eth_reg_access_arb #(.NUM_REGS(12), .ADDR_W(4), .DATA_W(32), .HOST_RO_MASK(12'h000)) dut12 (
        .Clk(Clk), .Reset(Reset),
        .HostReq(1'b0), .HostWe(1'b0), .HostAddr(4'd0), .HostWData(32'd0),
        .HostAck(h12_ack), .HostErr(h12_err), .HostRData(h12_rd),
        .MacReq(m12_req), .MacWe(1'b0), .MacAddr(m12_addr), .MacWData(32'd0),
        .MacAck(m12_ack), .MacErr(m12_err), .MacRData(m12_rd),
        .RegWrite(w12), .RegDataIn(d12_in), .RegDataOut(rdo12));

    always_comb begin
        for (int i = 0; i < 12; i++) rdo12[i*32 +: 32] = 32'hA000_0000 | 32'(i);
    end

    // Register bank driven by the DUT strobes.
    logic        bank_clr = 1'b1;
    logic [31:0] bank [16];
    always @(posedge Clk) begin
        for (int i = 0; i < 16; i++) begin
            if (bank_clr) bank[i] <= '0;
            else if (RegWrite[i]) bank[i] <= RegDataIn;
        end
    end
    always_comb begin
        for (int i = 0; i < 16; i++) RegDataOut[i*32 +: 32] = bank[i];
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: per-access phases (0 idle, 1 bank cycle, 2 completion)
    // plus a shadow of register contents.
    logic [15:0] e_strobe = 0;
    logic [31:0] e_din = 0, e_hrd = 0, e_mrd = 0;
    logic        e_hack = 0, e_herr = 0, e_mack = 0, e_merr = 0;
    logic [31:0] mdl_bank [16];
    int          phase = 0, t_addr = 0;
    bit          pref_mac = 0, who_mac = 0, t_we = 0, t_err = 0;

    always @(posedge Clk) begin
        if (bank_clr) for (int i = 0; i < 16; i++) mdl_bank[i] = '0;
        if (Reset) begin
            e_strobe = 0; e_din = 0; e_hrd = 0; e_mrd = 0;
            e_hack = 0; e_herr = 0; e_mack = 0; e_merr = 0;
            phase = 0; pref_mac = 0;
        end else if (phase == 0) begin
            e_strobe = 0;
            if (HostReq || MacReq) begin
                who_mac  = (HostReq && MacReq) ? pref_mac : MacReq;
                pref_mac = !who_mac;
                t_we     = who_mac ? MacWe : HostWe;
                t_addr   = who_mac ? int'(MacAddr) : int'(HostAddr);
                t_err    = (t_addr >= NREG) || (!who_mac && t_we && RO_MASK[t_addr]);
                if (t_we && !t_err) begin
                    e_strobe = 16'(1) << t_addr;
                    e_din    = who_mac ? MacWData : HostWData;
                    mdl_bank[t_addr] = e_din;
                end
                phase = 1;
            end
        end else if (phase == 1) begin
            e_strobe = 0;
            if (who_mac) begin
                e_mack = 1; e_merr = t_err;
                if (t_err) e_mrd = 0; else if (!t_we) e_mrd = mdl_bank[t_addr];
            end else begin
                e_hack = 1; e_herr = t_err;
                if (t_err) e_hrd = 0; else if (!t_we) e_hrd = mdl_bank[t_addr];
            end
            phase = 2;
        end else begin
            if (!(who_mac ? MacReq : HostReq)) begin
                e_hack = 0; e_herr = 0; e_mack = 0; e_merr = 0;
                phase = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            chk("RegWrite",  32'(RegWrite), 32'(e_strobe & {16{~Reset}}));
            chk("RegDataIn", RegDataIn, e_din);
            chk("HostAck",   32'(HostAck), 32'(e_hack));
            chk("HostErr",   32'(HostErr), 32'(e_herr));
            chk("HostRData", HostRData, e_hrd);
            chk("MacAck",    32'(MacAck), 32'(e_mack));
            chk("MacErr",    32'(MacErr), 32'(e_merr));
            chk("MacRData",  MacRData, e_mrd);
        end
    end

    logic [15:0] slog [$];
    always @(negedge Clk) if (RegWrite != 0) slog.push_back(RegWrite);

    task automatic chk_log(input string name, input int n, input logic [15:0] s0, input logic [15:0] s1);
        logic [15:0] a0, a1;
        a0 = (slog.size() > 0) ? slog[0] : 16'h0;
        a1 = (slog.size() > 1) ? slog[1] : 16'h0;
        chk({name, "_count"}, 32'(slog.size()), 32'(n));
        if (n > 0) chk({name, "_s0"}, 32'(a0), 32'(s0));
        if (n > 1) chk({name, "_s1"}, 32'(a1), 32'(s1));
    endtask

    task automatic access(input bit mac, input bit we, input logic [3:0] addr,
                          input logic [31:0] wd, input int hold,
                          output int lat, output logic err, output logic [31:0] rd);
        int  start;
        bit  seen;
        @(posedge Clk); #1;
        if (mac) begin MacReq = 1; MacWe = we; MacAddr = addr; MacWData = wd; end
        else     begin HostReq = 1; HostWe = we; HostAddr = addr; HostWData = wd; end
        start = cyc; seen = 0; lat = -1; err = 0; rd = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge Clk);
            if (mac ? MacAck : HostAck) begin
                seen = 1; lat = cyc - start;
                err = mac ? MacErr : HostErr;
                rd  = mac ? MacRData : HostRData;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout side=%0d: got no ack, expected ack within 40 cycles", mac);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            chk("ack_held", 32'(mac ? MacAck : HostAck), 32'd1);
        end
        @(posedge Clk); #1;
        if (mac) MacReq = 0; else HostReq = 0;
        for (int k = 0; k < 5 && (mac ? MacAck : HostAck); k++) @(negedge Clk);
        $display("access side=%0d we=%0d addr=%0d wd=%h lat=%0d err=%0d rd=%h", mac, we, addr, wd, lat, err, rd);
    endtask

    task automatic access12(input logic [3:0] addr, output logic err, output logic [31:0] rd);
        bit seen;
        @(posedge Clk); #1;
        m12_req = 1; m12_addr = addr; seen = 0; err = 0; rd = 32'hFFFF_FFFF;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge Clk);
            if (m12_ack) begin seen = 1; err = m12_err; rd = m12_rd; end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL ack12_timeout: got no ack, expected ack within 20 cycles");
        end
        @(posedge Clk); #1 m12_req = 0;
        repeat (3) @(posedge Clk);
        $display("access12 read addr=%0d err=%0d rd=%h", addr, err, rd);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1 Reset = 1;
        repeat (2) @(posedge Clk);
        #1 Reset = 0;
    endtask

    int          lat_h, lat_m;
    logic        err_h, err_m;
    logic [31:0] rd_h, rd_m;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge Clk); #1 check_en = 1;
        @(negedge Clk);
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_HostAck", 32'(HostAck), 32'd0);
        chk("rst_MacAck", 32'(MacAck), 32'd0);
        chk("rst_HostRData", HostRData, 32'd0);
        @(posedge Clk); #1 bank_clr = 0;
        @(posedge Clk); #1 Reset = 0;

        // Host write then read of register 3
        slog.delete();
        access(0, 1, 4'd3, 32'hDEADBEEF, 0, lat_h, err_h, rd_h);
        chk("t1_latency", 32'(lat_h), 32'd2);
        chk("t1_err", 32'(err_h), 32'd0);
        chk_log("t1_strobe", 1, 16'h0008, 16'h0);
        chk("t1_bank3", bank[3], 32'hDEADBEEF);
        slog.delete();
        access(0, 0, 4'd3, 32'h0, 0, lat_h, err_h, rd_h);
        chk("t2_rdata", rd_h, 32'hDEADBEEF);
        chk_log("t2_strobe", 0, 16'h0, 16'h0);

        // Simultaneous requests after reset: host first, then MAC
        do_reset();
        slog.delete();
        fork
            access(0, 1, 4'd1, 32'h1111_1111, 0, lat_h, err_h, rd_h);
            access(1, 1, 4'd2, 32'h2222_2222, 0, lat_m, err_m, rd_m);
        join
        chk_log("t3a_order", 2, 16'h0002, 16'h0004);
        access(0, 0, 4'd1, 32'h0, 0, lat_h, err_h, rd_h);
        chk("t3b_rdata", rd_h, 32'h1111_1111);
        slog.delete();
        fork
            access(0, 1, 4'd1, 32'h3333_3333, 0, lat_h, err_h, rd_h);
            access(1, 1, 4'd2, 32'h4444_4444, 0, lat_m, err_m, rd_m);
        join
        chk_log("t3c_order", 2, 16'h0004, 16'h0002);

        // Read-only register 4 and out-of-range address
        slog.delete();
        access(0, 1, 4'd4, 32'h9999_9999, 0, lat_h, err_h, rd_h);
        chk("t4_host_ro_err", 32'(err_h), 32'd1);
        chk_log("t4_host_ro_strobe", 0, 16'h0, 16'h0);
        access(1, 1, 4'd4, 32'h5555_5555, 0, lat_m, err_m, rd_m);
        chk("t4_mac_err", 32'(err_m), 32'd0);
        chk_log("t4_mac_strobe", 1, 16'h0010, 16'h0);
        access(0, 0, 4'd4, 32'h0, 0, lat_h, err_h, rd_h);
        chk("t4_host_ro_read_err", 32'(err_h), 32'd0);
        chk("t4_host_ro_read", rd_h, 32'h5555_5555);
        access12(4'd5, err_m, rd_m);
        chk("t4_12_read5_err", 32'(err_m), 32'd0);
        chk("t4_12_read5", rd_m, 32'hA000_0005);
        access12(4'd13, err_m, rd_m);
        chk("t4_12_read13_err", 32'(err_m), 32'd1);
        chk("t4_12_read13_rdata", rd_m, 32'd0);

        // Reset during GRANT of a host write
        slog.delete();
        @(posedge Clk); #1 HostReq = 1; HostWe = 1; HostAddr = 4'd7; HostWData = 32'hCAFE_0007;
        @(posedge Clk); #1 Reset = 1; HostReq = 0;
        @(negedge Clk);
        chk("t5_strobe_in_reset", 32'(RegWrite), 32'd0);
        @(posedge Clk); #1 Reset = 0;
        @(negedge Clk);
        chk("t5_post_HostAck", 32'(HostAck), 32'd0);
        chk("t5_post_RegDataIn", RegDataIn, 32'd0);
        chk("t5_post_HostRData", HostRData, 32'd0);
        chk("t5_post_MacRData", MacRData, 32'd0);
        chk("t5_bank7_untouched", bank[7], 32'd0);
        access(0, 1, 4'd7, 32'hCAFE_0007, 0, lat_h, err_h, rd_h);
        chk("t5_reissue_latency", 32'(lat_h), 32'd2);
        chk_log("t5_reissue_strobe", 1, 16'h0080, 16'h0);

        // Host holds its request after Ack while MAC waits
        slog.delete();
        fork
            access(0, 1, 4'd5, 32'h0505_0505, 5, lat_h, err_h, rd_h);
            begin
                @(posedge Clk);
                access(1, 1, 4'd6, 32'h0606_0606, 0, lat_m, err_m, rd_m);
            end
        join
        chk_log("t6_order", 2, 16'h0020, 16'h0040);
        chk("t6_bank6", bank[6], 32'h0606_0606);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
